// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit: one shift-add or restoring-subtract step per cycle,
// producing a {hi,lo} pair for MULT/MULTU/DIV/DIVU with a valid/ready handshake on each side.
module alu_muldiv #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cancel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy
);

    localparam int unsigned CNT_W  = $clog2(DATA_W) + 1;
    localparam int unsigned PROD_W = 2 * DATA_W;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic                is_div_q, is_signed_q, neg_q, neg_rem_q, div0_q;
    logic [DATA_W-1:0]   a_q, b_q, opd_q;
    logic [PROD_W-1:0]   acc_q;

    logic                accept, setup, last;
    logic [DATA_W-1:0]   mag_a, mag_b;
    logic [DATA_W:0]     mul_sum, div_shift, div_diff;
    logic [PROD_W-1:0]   step_nxt, prod_fix;
    logic [DATA_W-1:0]   hi_d, lo_d;

    // Operand magnitudes, one datapath step and final sign fix-up
    always_comb begin
        accept = (state_q == IDLE) && in_valid && !cancel;
        setup  = (cnt_q == CNT_W'(DATA_W));
        last   = (cnt_q == CNT_W'(0));
        mag_a  = (is_signed_q && a_q[DATA_W-1]) ? DATA_W'(0) - a_q : a_q;
        mag_b  = (is_signed_q && b_q[DATA_W-1]) ? DATA_W'(0) - b_q : b_q;

        mul_sum   = {1'b0, acc_q[PROD_W-1:DATA_W]} + ({1'b0, opd_q} & {(DATA_W+1){acc_q[0]}});
        div_shift = acc_q[PROD_W-1:DATA_W-1];
        div_diff  = div_shift - {1'b0, opd_q};

        if (is_div_q) begin
            // Remainder in the upper half, quotient bits shift into the lower half
            if (div_diff[DATA_W])
                step_nxt = {div_shift[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
            else
                step_nxt = {div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
        end else begin
            step_nxt = {mul_sum, acc_q[DATA_W-1:1]};
        end

        prod_fix = neg_q ? PROD_W'(0) - step_nxt : step_nxt;
        hi_d     = prod_fix[PROD_W-1:DATA_W];
        lo_d     = prod_fix[DATA_W-1:0];
        if (is_div_q) begin
            lo_d = neg_q     ? DATA_W'(0) - step_nxt[DATA_W-1:0]      : step_nxt[DATA_W-1:0];
            hi_d = neg_rem_q ? DATA_W'(0) - step_nxt[PROD_W-1:DATA_W] : step_nxt[PROD_W-1:DATA_W];
            if (div0_q) begin
                lo_d = '1;
                hi_d = a_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BUSY;
            BUSY:    if (cancel) state_d = IDLE;
                     else if (!setup && last) state_d = DONE;
            DONE:    if (cancel || out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d == IDLE);
            busy      <= (state_d != IDLE);
            out_valid <= (state_d == DONE);
        end
    end

    // Datapath: latch on accept, prepare magnitudes on the first BUSY cycle, then iterate
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q       <= '0;
            is_div_q    <= 1'b0;
            is_signed_q <= 1'b0;
            neg_q       <= 1'b0;
            neg_rem_q   <= 1'b0;
            div0_q      <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            opd_q       <= '0;
            acc_q       <= '0;
            hi          <= '0;
            lo          <= '0;
        end else if (accept) begin
            a_q         <= a;
            b_q         <= b;
            is_div_q    <= op[1];
            is_signed_q <= !op[0];
            cnt_q       <= CNT_W'(DATA_W);
        end else if (state_q == BUSY && !cancel) begin
            if (setup) begin
                opd_q     <= is_div_q ? mag_b : mag_a;
                acc_q     <= {DATA_W'(0), is_div_q ? mag_a : mag_b};
                neg_q     <= is_signed_q && (a_q[DATA_W-1] ^ b_q[DATA_W-1]);
                neg_rem_q <= is_signed_q && a_q[DATA_W-1];
                div0_q    <= (b_q == DATA_W'(0));
                cnt_q     <= cnt_q - CNT_W'(1);
            end else begin
                acc_q <= step_nxt;
                if (last) begin
                    hi <= hi_d;
                    lo <= lo_d;
                end else begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Bench for alu_muldiv: vector table on 32- and 8-bit instances with a result scoreboard,
// plus hand-written hold, back-to-back, cancel and reset sequences.
module tb_alu_muldiv;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid32, in_valid8;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        cancel, out_ready;
    logic        in_ready32, out_valid32, busy32;
    logic [31:0] hi32, lo32;
    logic        in_ready8, out_valid8, busy8;
    logic [7:0]  hi8, lo8;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    alu_muldiv #(.DATA_W(32)) dut32 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid32), .in_ready(in_ready32),
        .op(op), .a(a), .b(b), .cancel(cancel), .out_valid(out_valid32),
        .out_ready(out_ready), .hi(hi32), .lo(lo32), .busy(busy32)
    );

    alu_muldiv #(.DATA_W(8)) dut8 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid8), .in_ready(in_ready8),
        .op(op), .a(a[7:0]), .b(b[7:0]), .cancel(cancel), .out_valid(out_valid8),
        .out_ready(out_ready), .hi(hi8), .lo(lo8), .busy(busy8)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, eh, el;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic cur_rdy(input bit w8);
        return w8 ? in_ready8 : in_ready32;
    endfunction
    function automatic logic cur_ov(input bit w8);
        return w8 ? out_valid8 : out_valid32;
    endfunction
    function automatic logic [31:0] cur_hi(input bit w8);
        return w8 ? {24'h0, hi8} : hi32;
    endfunction
    function automatic logic [31:0] cur_lo(input bit w8);
        return w8 ? {24'h0, lo8} : lo32;
    endfunction

    // Issue one request, check latency/ready, optionally stall the consumer, then deliver
    task automatic run_op(input string nm, input bit w8, input logic [1:0] o,
                          input logic [31:0] aa, input logic [31:0] bb,
                          input logic [31:0] eh, input logic [31:0] el,
                          input int hold, output int wait_cyc);
        int          edges;
        bit          saw_rdy;
        logic [63:0] ex;
        wait_cyc = 0;
        @(negedge clk);
        while (!cur_rdy(w8) && wait_cyc < 200) begin
            @(negedge clk);
            wait_cyc++;
        end
        op = o; a = aa; b = bb;
        if (w8) in_valid8 = 1'b1; else in_valid32 = 1'b1;
        @(posedge clk);
        exp_q.push_back({eh, el});
        #1 in_valid8 = 1'b0; in_valid32 = 1'b0;
        edges = 0; saw_rdy = 1'b0;
        do begin
            @(posedge clk);
            edges++;
            #1;
            if (!cur_ov(w8) && cur_rdy(w8)) saw_rdy = 1'b1;
        end while (!cur_ov(w8) && edges < 100);
        chk({nm, " latency"}, 64'(edges), w8 ? 64'd9 : 64'd33);
        chk({nm, " in_ready_busy"}, 64'(saw_rdy), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({nm, " hold_valid"}, 64'(cur_ov(w8)), 64'd1);
            chk({nm, " hold_rdy"}, 64'(cur_rdy(w8)), 64'd0);
            chk({nm, " hold_hilo"}, {cur_hi(w8), cur_lo(w8)}, {eh, el});
        end
        @(negedge clk);
        out_ready = 1'b1;
        if (exp_q.size() == 0) begin
            chk({nm, " scoreboard_empty"}, 64'd1, 64'd0);
        end else begin
            ex = exp_q.pop_front();
            chk({nm, " hi"}, 64'(cur_hi(w8)), 64'(ex[63:32]));
            chk({nm, " lo"}, 64'(cur_lo(w8)), 64'(ex[31:0]));
        end
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        vec_t v32[12];
        vec_t v8[4];
        int   w;
        int   edges;
        bit   saw;

        v32[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        v32[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        v32[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        v32[3]  = '{2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
        v32[4]  = '{2'b11, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
        v32[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        v32[6]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        v32[7]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        v32[8]  = '{2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        v32[9]  = '{2'b00, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9};
        v32[10] = '{2'b01, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000};
        v32[11] = '{2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};

        v8[0] = '{2'b01, 32'hFF, 32'hFF, 32'hFE, 32'h01};
        v8[1] = '{2'b10, 32'h80, 32'hFF, 32'h00, 32'h80};
        v8[2] = '{2'b11, 32'h64, 32'h07, 32'h02, 32'h0E};
        v8[3] = '{2'b00, 32'hFD, 32'h05, 32'hFF, 32'hF1};

        resetn = 1'b0; in_valid32 = 1'b0; in_valid8 = 1'b0;
        op = 2'b00; a = '0; b = '0; cancel = 1'b0; out_ready = 1'b0;

        // Requests during reset must be dropped
        repeat (2) @(negedge clk);
        in_valid32 = 1'b1; a = 32'd5; b = 32'd3;
        repeat (2) @(negedge clk);
        chk("reset in_ready", 64'(in_ready32), 64'd1);
        chk("reset busy", 64'(busy32), 64'd0);
        chk("reset out_valid", 64'(out_valid32), 64'd0);
        chk("reset hilo", {hi32, lo32}, 64'd0);
        in_valid32 = 1'b0;
        resetn = 1'b1;
        @(negedge clk);
        chk("post_reset busy", 64'(busy32), 64'd0);

        foreach (v32[i])
            run_op($sformatf("v32[%0d]", i), 1'b0, v32[i].op, v32[i].a, v32[i].b,
                   v32[i].eh, v32[i].el, 0, w);
        foreach (v8[i])
            run_op($sformatf("v8[%0d]", i), 1'b1, v8[i].op, v8[i].a, v8[i].b,
                   v8[i].eh, v8[i].el, 0, w);

        // Consumer stalls 5 cycles, then a back-to-back request
        run_op("hold", 1'b0, 2'b01, 32'h0000FFFF, 32'h00010001, 32'h00000000, 32'hFFFFFFFF, 5, w);
        run_op("b2b", 1'b0, 2'b11, 32'd100, 32'd9, 32'd1, 32'd11, 0, w);
        chk("b2b accept_wait", 64'(w), 64'd0);

        // cancel in IDLE wins over in_valid
        @(negedge clk);
        op = 2'b11; a = 32'd9; b = 32'd3; in_valid32 = 1'b1; cancel = 1'b1;
        @(negedge clk);
        in_valid32 = 1'b0; cancel = 1'b0;
        chk("idle_cancel busy", 64'(busy32), 64'd0);

        // cancel mid-DIV: no result, ready again next cycle
        op = 2'b10; a = 32'hFFFFFF00; b = 32'd7; in_valid32 = 1'b1;
        @(posedge clk);
        #1 in_valid32 = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel out_valid", 64'(out_valid32), 64'd0);
        chk("cancel in_ready", 64'(in_ready32), 64'd1);
        saw = 1'b0;
        for (edges = 0; edges < 40; edges++) begin
            @(negedge clk);
            if (out_valid32) saw = 1'b1;
        end
        chk("cancel no_result", 64'(saw), 64'd0);
        run_op("after_cancel", 1'b0, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 0, w);

        // Asynchronous reset mid-MULT
        @(negedge clk);
        op = 2'b00; a = 32'd1234; b = 32'd5678; in_valid32 = 1'b1;
        @(posedge clk);
        #1 in_valid32 = 1'b0;
        repeat (5) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("async_rst busy", 64'(busy32), 64'd0);
        chk("async_rst in_ready", 64'(in_ready32), 64'd1);
        chk("async_rst out_valid", 64'(out_valid32), 64'd0);
        chk("async_rst hilo", {hi32, lo32}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        run_op("after_reset", 1'b0, 2'b11, 32'd7, 32'd2, 32'd1, 32'd3, 0, w);

        chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
